// File: rtl/pll_reset_seq.sv
// Reset sequencer for an external clock generator: pulses its reset, waits for a stable lock,
// then releases the downstream reset. Retries on lock timeout and re-sequences on lock loss.
module pll_reset_seq #(
    parameter int unsigned RST_PULSE    = 8,
    parameter int unsigned LOCK_TIMEOUT = 50000,
    parameter int unsigned SETTLE       = 1024,
    parameter int unsigned MAX_RETRY    = 3,
    localparam int unsigned RW          = $clog2(MAX_RETRY + 1)
) (
    input  logic          refclk,
    input  logic          rst,
    input  logic          pll_locked,
    output logic          pll_rst,
    output logic          sys_rst,
    output logic          ready,
    output logic          fail,
    output logic          lock_lost,
    output logic [RW-1:0] retries
);

    localparam int unsigned CNT_MAX =
        (LOCK_TIMEOUT > SETTLE) ? ((LOCK_TIMEOUT > RST_PULSE) ? LOCK_TIMEOUT : RST_PULSE)
                                : ((SETTLE > RST_PULSE) ? SETTLE : RST_PULSE);
    localparam int unsigned CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    // The SETTLE entry cycle already counts as one locked cycle, hence the extra -1.
    localparam logic [CW-1:0] SETTLE_LAST  = CW'((SETTLE >= 2) ? SETTLE - 2 : 0);
    localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        StReset,
        StWaitLock,
        StSettle,
        StRun,
        StFail
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          lk_meta;
    logic          lk_s;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= StReset;
            cnt_q     <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            lock_lost <= 1'b0;
            retries   <= '0;
            lk_meta   <= 1'b0;
            lk_s      <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk_s    <= lk_meta;
            cnt_q   <= cnt_q + 1'b1;
            case (state_q)
                StReset: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_q <= StWaitLock;
                        cnt_q   <= '0;
                        pll_rst <= 1'b0;
                    end
                end
                StWaitLock: begin
                    // Lock takes precedence over a coincident timeout.
                    if (lk_s) begin
                        state_q <= StSettle;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_q <= '0;
                        if (retries == RETRY_LAST) begin
                            state_q <= StFail;
                            fail    <= 1'b1;
                        end else begin
                            state_q <= StReset;
                            pll_rst <= 1'b1;
                            retries <= retries + 1'b1;
                        end
                    end
                end
                StSettle: begin
                    if (!lk_s) begin
                        state_q <= StWaitLock;
                        cnt_q   <= '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_q <= StRun;
                        cnt_q   <= '0;
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
                        retries <= '0;
                    end
                end
                StRun: begin
                    cnt_q <= '0;
                    if (!lk_s) begin
                        state_q   <= StReset;
                        pll_rst   <= 1'b1;
                        sys_rst   <= 1'b1;
                        ready     <= 1'b0;
                        lock_lost <= 1'b1;
                    end
                end
                StFail: begin
                    cnt_q <= '0;
                end
                default: begin
                    state_q <= StReset;
                    cnt_q   <= '0;
                    pll_rst <= 1'b1;
                    sys_rst <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule
